// File: rtl/bsrch_if.sv
// Load/select bundle between the sqrt binary-search controller and its datapath.
// The controller drives register loads and mux selects; the datapath returns status.
interface bsrch_if;
    logic       ld1;
    logic       ld2;
    logic       ld4;
    logic       ld5;
    logic       ld6;
    logic       ld7;
    logic       c1;
    logic       c2;
    logic [2:0] eqz;
    logic       signal;

    modport master (
        output ld1, ld2, ld4, ld5, ld6, ld7,
        output c1, c2,
        input  eqz, signal
    );

    modport slave (
        input  ld1, ld2, ld4, ld5, ld6, ld7,
        input  c1, c2,
        output eqz, signal
    );
endinterface

// File: rtl/bsrch_ctrl.sv
// Control FSM for the integer square-root binary-search datapath.
// Optional iteration limit / timeout enabled by defining BSRCH_ITER_LIMIT_EN.
module bsrch_ctrl #(
    parameter int MAX_ITER = 5
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     start,
    bsrch_if.master  dp,
    output logic     busy,
    output logic     done,
    output logic     exact,
    output logic     timeout
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_MID,
        S_SQR,
        S_CMP,
        S_SETTLE,
        S_CHK,
        S_DONE
    } state_t;

    state_t state;

    logic ld1, ld2, ld4, ld5, ld6, ld7;
    logic c1, c2;
    logic cmp_eq;
    logic cmp_lt;

    // Equal wins over less; anything else (including 000) narrows high.
    assign cmp_eq = dp.eqz[1];
    assign cmp_lt = dp.eqz[2] & ~dp.eqz[1];

`ifdef BSRCH_ITER_LIMIT_EN
    logic [2:0] iter_q;
    logic       timeout_q;
    logic       limit_hit;

    assign limit_hit = (int'(iter_q) >= MAX_ITER);
    assign timeout   = timeout_q;
`else
    localparam int unused_max_iter = MAX_ITER;
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            exact <= 1'b0;
`ifdef BSRCH_ITER_LIMIT_EN
            iter_q    <= 3'd0;
            timeout_q <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        state <= S_INIT;
                        busy  <= 1'b1;
                        exact <= 1'b0;
`ifdef BSRCH_ITER_LIMIT_EN
                        timeout_q <= 1'b0;
`endif
                    end
                end
                S_INIT: begin
                    state <= S_MID;
`ifdef BSRCH_ITER_LIMIT_EN
                    iter_q <= 3'd0;
`endif
                end
                S_MID: state <= S_SQR;
                S_SQR: state <= S_CMP;
                S_CMP: begin
`ifdef BSRCH_ITER_LIMIT_EN
                    if (iter_q != 3'd7)
                        iter_q <= iter_q + 3'd1;
`endif
                    if (cmp_eq) begin
                        state <= S_DONE;
                        done  <= 1'b1;
                        exact <= 1'b1;
`ifdef BSRCH_ITER_LIMIT_EN
                        timeout_q <= 1'b0;
`endif
                    end else begin
                        state <= S_SETTLE;
                    end
                end
                S_SETTLE: state <= S_CHK;
                S_CHK: begin
                    if (dp.signal) begin
                        state <= S_DONE;
                        done  <= 1'b1;
                        exact <= 1'b0;
`ifdef BSRCH_ITER_LIMIT_EN
                        timeout_q <= 1'b0;
                    end else if (limit_hit) begin
                        state     <= S_DONE;
                        done      <= 1'b1;
                        exact     <= 1'b0;
                        timeout_q <= 1'b1;
`endif
                    end else begin
                        state <= S_MID;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                    exact <= 1'b0;
`ifdef BSRCH_ITER_LIMIT_EN
                    timeout_q <= 1'b0;
`endif
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Moore loads everywhere except CMP, where the compare flags steer low/high.
    always_comb begin
        ld1 = 1'b0;
        ld2 = 1'b0;
        ld4 = 1'b0;
        ld5 = 1'b0;
        ld6 = 1'b0;
        ld7 = 1'b0;
        c1  = 1'b0;
        c2  = 1'b0;
        unique case (state)
            S_INIT: begin
                ld1 = 1'b1;
                ld2 = 1'b1;
            end
            S_MID: ld4 = 1'b1;
            S_SQR: begin
                ld5 = 1'b1;
                ld6 = 1'b1;
                ld7 = 1'b1;
            end
            S_CMP: begin
                if (cmp_lt) begin
                    ld1 = 1'b1;
                    c1  = 1'b1;
                end else if (!cmp_eq) begin
                    ld2 = 1'b1;
                    c2  = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign dp.ld1 = ld1;
    assign dp.ld2 = ld2;
    assign dp.ld4 = ld4;
    assign dp.ld5 = ld5;
    assign dp.ld6 = ld6;
    assign dp.ld7 = ld7;
    assign dp.c1  = c1;
    assign dp.c2  = c2;

endmodule

// File: tb/tb_bsrch_ctrl.sv
// Bench for bsrch_ctrl: schedule-based reference model of the search timing
// driven with directed and randomized compare/status sequences.
module tb_bsrch_ctrl;

    localparam int MAXI = 5;
`ifdef BSRCH_ITER_LIMIT_EN
    localparam bit LIM = 1'b1;
`else
    localparam bit LIM = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    logic start;
    logic busy, done, exact, timeout;

    bsrch_if dp();

    bsrch_ctrl #(.MAX_ITER(MAXI)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .dp      (dp),
        .busy    (busy),
        .done    (done),
        .exact   (exact),
        .timeout (timeout)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int errors  = 0;

    bit [2:0] ez [1:40];
    bit       sg [1:40];
    int       nit;

    // {busy, done, ld1, ld2, ld4, ld5, ld6, ld7, c1, c2}
    function automatic logic [9:0] obs();
        return {busy, done, dp.ld1, dp.ld2, dp.ld4, dp.ld5,
                dp.ld6, dp.ld7, dp.c1, dp.c2};
    endfunction

    // Runs one accepted search. Cycle c is the c-th cycle after the start
    // edge; iteration k occupies cycles 5k-3 .. 5k+1 (MID SQR CMP SETTLE CHK).
    task automatic run_search(input bit do_start, input bit chain,
                              input bit noise, input string nm);
        int dc;
        int k, ph;
        bit ex, to;
        logic [9:0] exp_v;
        dc = 0;
        ex = 1'b0;
        to = 1'b0;
        for (int i = 1; i <= nit; i++) begin
            if (ez[i][1]) begin
                dc = 5 * i;
                ex = 1'b1;
                break;
            end
            if (sg[i]) begin
                dc = 5 * i + 2;
                break;
            end
            if (LIM && (((i > 7) ? 7 : i) >= MAXI)) begin
                dc = 5 * i + 2;
                to = 1'b1;
                break;
            end
        end
        if (dc == 0) begin
            errors++;
            $display("FAIL %s: no terminating iteration in stimulus (got %0d, need >0)", nm, dc);
            return;
        end
        if (do_start) begin
            @(negedge clk);
            start     = 1'b1;
            dp.eqz    = 3'($urandom);
            dp.signal = 1'($urandom);
            #1;
            vectors++;
            if (obs() !== 10'b0) begin
                errors++;
                $display("FAIL %s idle: got %b want %b", nm, obs(), 10'b0);
            end
        end
        for (int c = 1; c <= dc + 1; c++) begin
            @(negedge clk);
            if (c == dc + 1)
                start = chain;
            else
                start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            dp.eqz    = noise ? 3'($urandom) : 3'b000;
            dp.signal = noise ? 1'($urandom) : 1'b0;
            k  = (c >= 2) ? (c - 2) / 5 + 1 : 0;
            ph = (c >= 2) ? (c - 2) % 5 : -1;
            if (c >= 2 && c < dc) begin
                if (ph == 2) dp.eqz = ez[k];
                if (ph == 4) dp.signal = sg[k];
            end
            if (c == dc + 1)      exp_v = 10'b00_0000_0000;
            else if (c == dc)     exp_v = 10'b11_0000_0000;
            else if (c == 1)      exp_v = 10'b10_1100_0000;
            else begin
                case (ph)
                    0: exp_v = 10'b10_0010_0000;
                    1: exp_v = 10'b10_0001_1100;
                    2: begin
                        if (ez[k][1])      exp_v = 10'b10_0000_0000;
                        else if (ez[k][2]) exp_v = 10'b10_1000_0010;
                        else               exp_v = 10'b10_0100_0001;
                    end
                    default: exp_v = 10'b10_0000_0000;
                endcase
            end
            #1;
            vectors++;
            if (obs() !== exp_v) begin
                errors++;
                $display("FAIL %s cyc%0d: got %b want %b", nm, c, obs(), exp_v);
            end
            if (c == dc) begin
                vectors++;
                if ({exact, timeout} !== {ex, to}) begin
                    errors++;
                    $display("FAIL %s result: exact/timeout got %b%b want %b%b",
                             nm, exact, timeout, ex, to);
                end
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b0;
        dp.eqz = 3'b000;
        dp.signal = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        vectors++;
        if ({obs(), exact, timeout} !== 12'b0) begin
            errors++;
            $display("FAIL reset: got %b want %b", {obs(), exact, timeout}, 12'b0);
        end
        rst = 1'b0;
    endtask

    task automatic test_exact_first();
        nit = 1;
        ez[1] = 3'b010;
        sg[1] = 1'b0;
        run_search(1'b1, 1'b0, 1'b0, "exact_first");
    endtask

    task automatic test_n50();
        nit = 3;
        ez[1] = 3'b100; sg[1] = 1'b0;
        ez[2] = 3'b001; sg[2] = 1'b0;
        ez[3] = 3'b001; sg[3] = 1'b1;
        run_search(1'b1, 1'b0, 1'b0, "n50");
    endtask

    task automatic test_illegal();
        nit = 1;
        ez[1] = 3'b111;
        sg[1] = 1'b1;
        run_search(1'b1, 1'b0, 1'b1, "eqz111");
        nit = 2;
        ez[1] = 3'b000; sg[1] = 1'b0;
        ez[2] = 3'b101; sg[2] = 1'b1;
        run_search(1'b1, 1'b0, 1'b1, "eqz000");
    endtask

    task automatic test_timeout();
        nit = 30;
        for (int i = 1; i <= 30; i++) begin
            ez[i] = 3'b100;
            sg[i] = 1'b0;
        end
        if (LIM) begin
            run_search(1'b1, 1'b0, 1'b0, "timeout");
        end else begin
            @(negedge clk);
            start = 1'b1;
            dp.eqz = 3'b100;
            dp.signal = 1'b0;
            @(negedge clk);
            start = 1'b0;
            for (int c = 1; c <= 100; c++) begin
                #1;
                vectors++;
                if ({busy, done} !== 2'b10) begin
                    errors++;
                    $display("FAIL no_limit cyc%0d: busy/done got %b want %b", c, {busy, done}, 2'b10);
                end
                @(negedge clk);
            end
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            #1;
            vectors++;
            if (obs() !== 10'b0) begin
                errors++;
                $display("FAIL no_limit reset: got %b want %b", obs(), 10'b0);
            end
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        vectors++;
        if (obs() !== 10'b10_0001_1100) begin
            errors++;
            $display("FAIL rst_mid sqr: got %b want %b", obs(), 10'b10_0001_1100);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        vectors++;
        if ({obs(), exact, timeout} !== 12'b0) begin
            errors++;
            $display("FAIL rst_mid after: got %b want %b", {obs(), exact, timeout}, 12'b0);
        end
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            dp.eqz = 3'($urandom);
            dp.signal = 1'($urandom);
            #1;
            vectors++;
            if (obs() !== 10'b0) begin
                errors++;
                $display("FAIL rst_mid idle%0d: got %b want %b", c, obs(), 10'b0);
            end
        end
        nit = 1;
        ez[1] = 3'b100;
        sg[1] = 1'b1;
        run_search(1'b1, 1'b0, 1'b0, "rst_mid_restart");
    endtask

    task automatic test_back_to_back();
        nit = 1;
        ez[1] = 3'b010;
        sg[1] = 1'b0;
        run_search(1'b1, 1'b1, 1'b0, "b2b_first");
        ez[1] = 3'b001;
        sg[1] = 1'b1;
        run_search(1'b0, 1'b0, 1'b0, "b2b_second");
    endtask

    task automatic test_random();
        bit chain, prev_chain;
        prev_chain = 1'b0;
        for (int r = 0; r < 30; r++) begin
            nit = int'($urandom_range(1, 4));
            for (int i = 1; i <= nit; i++) begin
                ez[i] = 3'($urandom);
                sg[i] = ($urandom_range(0, 2) == 0);
            end
            sg[nit] = 1'b1;
            chain = (r != 29) && ($urandom_range(0, 3) == 0);
            run_search(!prev_chain, chain, 1'b1, "random");
            prev_chain = chain;
        end
    endtask

    initial begin
        test_reset();
        test_exact_first();
        test_n50();
        test_illegal();
        test_reset_mid();
        test_back_to_back();
        test_timeout();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
